// File: rtl/led_row_scanner.sv
// LED matrix row sequencer: per row, blank for BLANK_CLKS cycles, strobe the column latch once,
// then drive the row for DWELL_MS ms ticks; frame_done pulses on each wrap back to row 0.
module led_row_scanner #(
    parameter int ROWS       = 8,
    parameter int ROW_W      = 3,
    parameter int DWELL_MS   = 2,
    parameter int BLANK_CLKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ms_tick,
    output logic [ROWS-1:0]  row_en,
    output logic [ROW_W-1:0] row_idx,
    output logic             col_latch,
    output logic             frame_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        LATCH = 2'd2,
        DRIVE = 2'd3
    } state_t;

    localparam logic [3:0]       BLANK_LAST = 4'(BLANK_CLKS - 1);
    localparam logic [3:0]       DWELL_LAST = 4'(DWELL_MS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [ROWS-1:0]  ROW_ONE    = ROWS'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_blank_cnt;
    logic [3:0]       w_blank_cnt_nxt;
    logic [3:0]       r_dwell_cnt;
    logic [3:0]       w_dwell_cnt_nxt;
    logic [ROW_W-1:0] r_row_idx;
    logic [ROW_W-1:0] w_row_idx_nxt;
    logic             w_frame_done_nxt;

    always_comb begin
        w_state_nxt      = r_state;
        w_blank_cnt_nxt  = r_blank_cnt;
        w_dwell_cnt_nxt  = r_dwell_cnt;
        w_row_idx_nxt    = r_row_idx;
        w_frame_done_nxt = 1'b0;

        // Disable wins over everything, including a row-completing tick on the last row.
        if (!enable) begin
            w_state_nxt     = IDLE;
            w_blank_cnt_nxt = '0;
            w_dwell_cnt_nxt = '0;
            w_row_idx_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt     = BLANK;
                    w_blank_cnt_nxt = '0;
                    w_dwell_cnt_nxt = '0;
                    w_row_idx_nxt   = '0;
                end
                BLANK: begin
                    if (r_blank_cnt == BLANK_LAST) begin
                        w_state_nxt     = LATCH;
                        w_blank_cnt_nxt = '0;
                    end else begin
                        w_blank_cnt_nxt = r_blank_cnt + 4'd1;
                    end
                end
                LATCH: begin
                    w_state_nxt     = DRIVE;
                    w_dwell_cnt_nxt = '0;
                end
                DRIVE: begin
                    if (ms_tick) begin
                        if (r_dwell_cnt == DWELL_LAST) begin
                            w_state_nxt     = BLANK;
                            w_blank_cnt_nxt = '0;
                            w_dwell_cnt_nxt = '0;
                            if (r_row_idx == ROW_LAST) begin
                                w_row_idx_nxt    = '0;
                                w_frame_done_nxt = 1'b1;
                            end else begin
                                w_row_idx_nxt = r_row_idx + ROW_W'(1);
                            end
                        end else begin
                            w_dwell_cnt_nxt = r_dwell_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt     = IDLE;
                    w_blank_cnt_nxt = '0;
                    w_dwell_cnt_nxt = '0;
                    w_row_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_blank_cnt <= '0;
            r_dwell_cnt <= '0;
            r_row_idx   <= '0;
            row_en      <= '0;
            row_idx     <= '0;
            col_latch   <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_blank_cnt <= w_blank_cnt_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_row_idx   <= w_row_idx_nxt;
            row_en      <= (w_state_nxt == DRIVE) ? (ROW_ONE << w_row_idx_nxt) : '0;
            row_idx     <= w_row_idx_nxt;
            col_latch   <= (w_state_nxt == LATCH);
            frame_done  <= w_frame_done_nxt;
            busy        <= (w_state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_led_row_scanner.sv
// Directed bench for led_row_scanner (ROWS=8, DWELL_MS=2, BLANK_CLKS=4) plus a random invariant run.
module tb_led_row_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       ms_tick = 1'b0;
    logic [7:0] row_en;
    logic [2:0] row_idx;
    logic       col_latch;
    logic       frame_done;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    led_row_scanner #(
        .ROWS(8), .ROW_W(3), .DWELL_MS(2), .BLANK_CLKS(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .ms_tick(ms_tick),
        .row_en(row_en), .row_idx(row_idx), .col_latch(col_latch),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs set before step() are sampled at its edge; outputs are read 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; ms_tick = 1'b0;
        repeat (3) step();
        n_total++; if (row_en !== 8'h00) $display("FAIL rst_row_en: got %h expected 00", row_en); else n_pass++;
        n_total++; if (row_idx !== 3'd0) $display("FAIL rst_row_idx: got %0d expected 0", row_idx); else n_pass++;
        n_total++; if ({col_latch, frame_done, busy} !== 3'b000)
            $display("FAIL rst_flags: got %b expected 000", {col_latch, frame_done, busy}); else n_pass++;
        rst = 1'b1;
        step();
        n_total++; if (busy !== 1'b1 || row_en !== 8'h00)
            $display("FAIL rel_busy: got busy=%b row_en=%h expected busy=1 row_en=00", busy, row_en); else n_pass++;
        repeat (3) step();
        n_total++; if (row_en !== 8'h00 || col_latch !== 1'b0)
            $display("FAIL rel_blank: got row_en=%h col_latch=%b expected 00/0", row_en, col_latch); else n_pass++;
        step();
        n_total++; if (col_latch !== 1'b1 || row_idx !== 3'd0 || row_en !== 8'h00)
            $display("FAIL rel_latch: got col_latch=%b idx=%0d row_en=%h expected 1/0/00", col_latch, row_idx, row_en); else n_pass++;
        step();
        n_total++; if (row_en !== 8'h01 || col_latch !== 1'b0)
            $display("FAIL rel_drive: got row_en=%h col_latch=%b expected 01/0", row_en, col_latch); else n_pass++;
    endtask

    // Entered on the first DRIVE cycle of row idx; leaves on the first DRIVE cycle of the next row.
    // With ign set, ms_tick is held high through BLANK and LATCH, which must not count.
    task automatic run_row(input int idx, input bit ign);
        logic [7:0] exp_en;
        logic [2:0] nxt;
        exp_en = 8'd1 << idx;
        nxt    = 3'((idx + 1) % 8);
        n_total++; if (row_en !== exp_en)
            $display("FAIL row%0d_drive: got %h expected %h", idx, row_en, exp_en); else n_pass++;
        for (int t = 0; t < 2; t++) begin
            ms_tick = 1'b0;
            repeat (9) step();
            ms_tick = 1'b1;
            step();
            ms_tick = 1'b0;
            if (t == 0) begin
                n_total++; if (row_en !== exp_en)
                    $display("FAIL row%0d_after_tick1: got %h expected %h", idx, row_en, exp_en); else n_pass++;
            end
        end
        n_total++; if (row_en !== 8'h00 || row_idx !== nxt || busy !== 1'b1)
            $display("FAIL row%0d_end: got row_en=%h idx=%0d busy=%b expected 00/%0d/1", idx, row_en, row_idx, busy, nxt); else n_pass++;
        n_total++; if (frame_done !== (nxt == 3'd0))
            $display("FAIL row%0d_frame_done: got %b expected %b", idx, frame_done, (nxt == 3'd0)); else n_pass++;
        ms_tick = ign;
        repeat (3) step();
        n_total++; if (row_en !== 8'h00 || col_latch !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL row%0d_blank: got row_en=%h col_latch=%b fd=%b expected 00/0/0", idx, row_en, col_latch, frame_done); else n_pass++;
        step();
        n_total++; if (col_latch !== 1'b1 || row_idx !== nxt || row_en !== 8'h00)
            $display("FAIL row%0d_latch: got col_latch=%b idx=%0d row_en=%h expected 1/%0d/00", idx, col_latch, row_idx, row_en, nxt); else n_pass++;
        step();
        ms_tick = 1'b0;
    endtask

    task automatic test_dwell();
        run_row(0, 1'b0);
    endtask

    task automatic test_full_frame();
        for (int r = 1; r < 8; r++) run_row(r, 1'b0);
        for (int r = 0; r < 8; r++) run_row(r, 1'b0);
    endtask

    task automatic test_ignored_ticks();
        for (int r = 0; r < 8; r++) run_row(r, 1'b1);
    endtask

    task automatic test_disable();
        for (int r = 0; r < 5; r++) run_row(r, 1'b0);
        repeat (3) step();
        n_total++; if (row_en !== 8'h20) $display("FAIL dis_row5: got %h expected 20", row_en); else n_pass++;
        enable = 1'b0;
        step();
        n_total++; if (row_en !== 8'h00 || row_idx !== 3'd0 || busy !== 1'b0)
            $display("FAIL dis_idle: got row_en=%h idx=%0d busy=%b expected 00/0/0", row_en, row_idx, busy); else n_pass++;
        n_total++; if (frame_done !== 1'b0 || col_latch !== 1'b0)
            $display("FAIL dis_pulses: got fd=%b col_latch=%b expected 0/0", frame_done, col_latch); else n_pass++;
        step();
        enable = 1'b1;
        step();
        n_total++; if (busy !== 1'b1 || row_en !== 8'h00 || row_idx !== 3'd0)
            $display("FAIL reen_blank: got busy=%b row_en=%h idx=%0d expected 1/00/0", busy, row_en, row_idx); else n_pass++;
        repeat (3) step();
        n_total++; if (col_latch !== 1'b0) $display("FAIL reen_blank4: got col_latch=%b expected 0", col_latch); else n_pass++;
        step();
        n_total++; if (col_latch !== 1'b1 || row_idx !== 3'd0)
            $display("FAIL reen_latch: got col_latch=%b idx=%0d expected 1/0", col_latch, row_idx); else n_pass++;
        step();
        n_total++; if (row_en !== 8'h01) $display("FAIL reen_drive: got %h expected 01", row_en); else n_pass++;
    endtask

    task automatic test_simultaneous();
        for (int r = 0; r < 7; r++) run_row(r, 1'b0);
        ms_tick = 1'b1;
        step();
        ms_tick = 1'b0;
        repeat (5) step();
        n_total++; if (row_en !== 8'h80) $display("FAIL sim_row7: got %h expected 80", row_en); else n_pass++;
        ms_tick = 1'b1; enable = 1'b0;
        step();
        ms_tick = 1'b0;
        n_total++; if (frame_done !== 1'b0 || busy !== 1'b0 || row_en !== 8'h00 || row_idx !== 3'd0)
            $display("FAIL sim_idle: got fd=%b busy=%b row_en=%h idx=%0d expected 0/0/00/0", frame_done, busy, row_en, row_idx); else n_pass++;
        step();
        n_total++; if (frame_done !== 1'b0) $display("FAIL sim_fd_late: got %b expected 0", frame_done); else n_pass++;
    endtask

    task automatic test_random();
        int viol = 0;
        logic [7:0] one = 8'd1;
        rst = 1'b0; step(); rst = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            enable  = ($urandom_range(0, 99) < 97);
            ms_tick = ($urandom_range(0, 7) == 0);
            step();
            if ((row_en & (row_en - 8'd1)) != 8'h00) viol++;
            if (row_en != 8'h00 && col_latch) viol++;
            if (row_en != 8'h00 && frame_done) viol++;
            if (row_en != 8'h00 && !busy) viol++;
            if (row_en != 8'h00 && row_en != (one << row_idx)) viol++;
        end
        enable = 1'b0; ms_tick = 1'b0;
        n_total++; if (viol !== 0) $display("FAIL random_invariants: got %0d violations expected 0", viol); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_dwell();
        test_full_frame();
        test_ignored_ticks();
        test_disable();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_row_scanner.md
Name: led_row_scanner

Overview:
- Consumes the 1 ms tick produced by the millisecond timer stage and sequences LED matrix rows.
- Each row runs through three phases: a blanking interval to prevent ghosting, a one-cycle column-latch strobe to the column shift stage, then a dwell of a programmable number of ms ticks with that row driven.
- Emits a frame-done pulse on every wrap from the last row back to row 0.

Parameters:
- ROWS, 8, number of matrix rows (2..16).
- ROW_W, 3, width of row_idx; must satisfy 2^ROW_W >= ROWS.
- DWELL_MS, 2, ms ticks each row is driven (1..15).
- BLANK_CLKS, 4, clk cycles of blanking before each row (1..15).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-low.
- enable  input  1  level; 1 = scan, 0 = idle/blank.
- ms_tick  input  1  single-cycle 1 ms pulse from upstream timer.
- row_en  output  ROWS  one-hot row drive, active-high; all 0 when not driving.
- row_idx  output  ROW_W  index of the current/next row.
- col_latch  output  1  1-cycle strobe: column data for row_idx must be loaded.
- frame_done  output  1  1-cycle pulse on wrap ROWS-1 -> 0.
- busy  output  1  1 in any state other than IDLE.

Behaviour:
- All outputs registered. Reset (rst=0 at a clk edge):
  - state=IDLE, row_en=0, row_idx=0, col_latch=0, frame_done=0, busy=0.
  - Blank and dwell counters are cleared.
  - Reset overrides everything, including mid-row.
- States: IDLE, BLANK, LATCH, DRIVE.
- IDLE:
  - row_en=0, row_idx=0.
  - enable=1 sampled -> BLANK on the next cycle, blank counter=0.
- BLANK:
  - row_en=0.
  - Counter increments each clk; after exactly BLANK_CLKS cycles in BLANK -> LATCH.
- LATCH:
  - Exactly 1 cycle; col_latch=1 in this cycle only; row_en=0.
  - Then DRIVE, dwell counter=0.
- DRIVE:
  - row_en has a single 1 at bit row_idx.
  - Each ms_tick=1 sampled increments the dwell counter.
  - On the tick where count==DWELL_MS-1, the next cycle is BLANK. That BLANK cycle has row_en=0 and row_idx=row_idx+1, wrapping ROWS-1 -> 0.
  - On wrap, frame_done=1 for that first BLANK cycle only.
- ms_tick is ignored in IDLE, BLANK and LATCH; ticks are not queued.
- A partially elapsed dwell is never carried over to the next row.
- enable=0 sampled in any state -> IDLE on the next cycle:
  - row_en=0, row_idx=0, counters cleared, no col_latch and no frame_done.
  - A subsequent enable=1 restarts from row 0 with a full BLANK.
- Simultaneous enable=0 and the final ms_tick in DRIVE: enable wins; no frame_done even if row_idx=ROWS-1.
- row_en and col_latch are never 1 in the same cycle.
- row_en is never nonzero in BLANK/LATCH/IDLE, and never has more than one bit set.
- Per-row period = BLANK_CLKS + 1 + (cycles to collect DWELL_MS ticks).

Test Plan:
- Reset check: rst=0 with enable=1 for 3 cycles -> all outputs 0, state IDLE. Release rst with enable=1 -> busy=1 next cycle; row_en=0 for 4 cycles; col_latch=1 on cycle 5 with row_idx=0; row_en=8'b00000001 from cycle 6.
- Dwell timing: ms_tick every 10 clks, DWELL_MS=2 -> row 0 driven until the cycle after the 2nd tick seen in DRIVE. Next cycle: row_en=0, row_idx=1; col_latch 4 cycles later; then row_en=8'b00000010.
- Full frame: run 8 rows -> row_en walks bit 0..7. frame_done=1 for exactly one cycle as row_idx goes 7 -> 0, coincident with row_en=0. Second frame is identical.
- Ignored ticks: ms_tick asserted during BLANK and LATCH -> dwell count unaffected. Row 0 still needs 2 DRIVE-phase ticks.
- Mid-operation disable: drop enable while driving row 5 -> next cycle row_en=0, row_idx=0, busy=0, no frame_done. Re-enable -> 4 blank cycles, then col_latch with row_idx=0.
- Simultaneity: enable=0 on the same cycle as the final tick of row 7 -> IDLE, frame_done stays 0. A one-hot/exclusivity assertion holds across a 10,000-cycle random enable/ms_tick run.
